// File: rtl/bin7_to_bcd.sv
// Sequential 7-bit binary to 3-digit BCD converter using shift-and-add-3 (double dabble).
// state | meaning: IDLE wait for start | SHIFT seven add-3/shift steps | DONE one-cycle result pulse
module bin7_to_bcd (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] din,
  output logic       busy,
  output logic       done,
  output logic [3:0] bcd_hund,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [6:0]  binreg;
  logic [11:0] scratch;
  logic [11:0] scratch_adj;
  logic [11:0] scratch_shl;
  logic [2:0]  cnt;
  logic        last_shift;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  always_comb begin
    scratch_adj = {add3(scratch[11:8]), add3(scratch[7:4]), add3(scratch[3:0])};
    scratch_shl = {scratch_adj[10:0], binreg[6]};
    last_shift  = (cnt == 3'd6);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_shift) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // The final shift result goes straight to the digit outputs, so they change only on DONE entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      binreg   <= 7'd0;
      scratch  <= 12'd0;
      cnt      <= 3'd0;
      done     <= 1'b0;
      bcd_hund <= 4'd0;
      bcd_tens <= 4'd0;
      bcd_ones <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            binreg  <= din;
            scratch <= 12'd0;
            cnt     <= 3'd0;
          end
        end
        SHIFT: begin
          scratch <= scratch_shl;
          binreg  <= {binreg[5:0], 1'b0};
          cnt     <= cnt + 3'd1;
          if (last_shift) begin
            bcd_hund <= scratch_shl[11:8];
            bcd_tens <= scratch_shl[7:4];
            bcd_ones <= scratch_shl[3:0];
            done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
